// File: rtl/elevator_emergency_pkg.sv
// ---------------------------------------------------------------------------
// elevator_emergency_pkg
// Shared types and default timing constants for the elevator emergency
// subsystem blocks (overload interlock and friends).
//   ovl_state_t            : overload interlock FSM state encoding
//   DEF_DEBOUNCE_CYCLES    : synchronised-high cycles needed to declare overload
//   DEF_CLEAR_CYCLES       : synchronised-low cycles needed to release overload
//   DEF_BUZZ_HALF_PERIOD   : buzzer on/off half-period in clock cycles
//   is_latched()           : true for the states in which overload is asserted
// ---------------------------------------------------------------------------
package elevator_emergency_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        OVERLOAD = 2'd2,
        RELEASE  = 2'd3
    } ovl_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES  = 32'd8;
    localparam int unsigned DEF_CLEAR_CYCLES     = 32'd16;
    localparam int unsigned DEF_BUZZ_HALF_PERIOD = 32'd4;
    localparam int unsigned DEF_CNT_W            = 32'd5;
    localparam int unsigned DEF_EVT_W            = 32'd8;

    // OVERLOAD and RELEASE both present the overload outputs to the car.
    function automatic logic is_latched(input ovl_state_t s);
        return (s == OVERLOAD) || (s == RELEASE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchroniser for bringing an asynchronous level into
// the clk domain. Both stages clear on reset.
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input level
//   q     : synchronised level, two clocks behind d
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic ff1_q;
    logic ff2_q;

    // Two-stage capture; the first stage may go metastable, the second filters it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/overload_interlock.sv
// ---------------------------------------------------------------------------
// overload_interlock
// Consumes the weight-limit flag from weight_control, debounces it and
// latches an overload condition. While overloaded the doors are held open,
// car motion is inhibited and an intermittent buzzer sounds. Release needs
// the flag to stay clear for a full qualification window.
//
// Optional feature (macro OVERLOAD_EVENT_COUNTER_EN): adds parameter EVT_W
// and output overload_events, a saturating count of fresh overload entries.
//
// Ports:
//   clk                   : system clock, rising edge
//   rst_n                 : asynchronous active-low reset
//   weight_limit_exceeded : raw flag, asynchronous to clk
//   car_moving            : 1 while the car travels; blocks overload entry only
//   overload_active       : registered, 1 while overload is latched
//   door_hold_open        : registered, keep/reopen doors request
//   motion_inhibit        : registered, blocks departure
//   buzzer                : registered, intermittent alarm drive
//   overload_events       : saturating entry count (macro builds only)
// ---------------------------------------------------------------------------
module overload_interlock
    import elevator_emergency_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CLEAR_CYCLES     = DEF_CLEAR_CYCLES,
    parameter int unsigned BUZZ_HALF_PERIOD = DEF_BUZZ_HALF_PERIOD,
    parameter int unsigned CNT_W            = DEF_CNT_W
`ifdef OVERLOAD_EVENT_COUNTER_EN
    ,
    parameter int unsigned EVT_W            = DEF_EVT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             weight_limit_exceeded,
    input  logic             car_moving,
    output logic             overload_active,
    output logic             door_hold_open,
    output logic             motion_inhibit,
    output logic             buzzer
`ifdef OVERLOAD_EVENT_COUNTER_EN
    ,
    output logic [EVT_W-1:0] overload_events
`endif
);

    localparam int unsigned BZ_W = (BUZZ_HALF_PERIOD > 32'd1) ? $clog2(BUZZ_HALF_PERIOD) : 32'd1;

    logic             lim_s;
    ovl_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BZ_W-1:0]  bz_cnt_q, bz_cnt_d;
    logic             latched_q, latched_d;
    logic             buzzer_q, buzzer_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (weight_limit_exceeded),
        .q     (lim_s)
    );

    // Next-state and qualification counter. The counter holds the number of
    // qualifying samples seen so far, so the transition fires on the sample
    // that makes it reach the threshold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (lim_s && !car_moving) begin
                    state_d = CONFIRM;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            CONFIRM: begin
                if (!lim_s || car_moving) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 32'd1)) begin
                    state_d = OVERLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            OVERLOAD: begin
                if (!lim_s) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (lim_s) begin
                    state_d = OVERLOAD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(CLEAR_CYCLES - 32'd1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the state being entered so they rise together with the
    // state register. The buzzer phase only restarts on a fresh entry; an
    // OVERLOAD<->RELEASE bounce keeps the running phase.
    always_comb begin
        latched_d = is_latched(state_d);
        buzzer_d  = 1'b0;
        bz_cnt_d  = '0;
        if (!latched_d) begin
            buzzer_d = 1'b0;
            bz_cnt_d = '0;
        end else if (!is_latched(state_q)) begin
            buzzer_d = 1'b1;
            bz_cnt_d = '0;
        end else if (bz_cnt_q == BZ_W'(BUZZ_HALF_PERIOD - 32'd1)) begin
            buzzer_d = ~buzzer_q;
            bz_cnt_d = '0;
        end else begin
            buzzer_d = buzzer_q;
            bz_cnt_d = bz_cnt_q + BZ_W'(1);
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bz_cnt_q  <= '0;
            latched_q <= 1'b0;
            buzzer_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bz_cnt_q  <= bz_cnt_d;
            latched_q <= latched_d;
            buzzer_q  <= buzzer_d;
        end
    end

    assign overload_active = latched_q;
    assign door_hold_open  = latched_q;
    assign motion_inhibit  = latched_q;
    assign buzzer          = buzzer_q;

`ifdef OVERLOAD_EVENT_COUNTER_EN
    logic [EVT_W-1:0] evt_q, evt_d;

    // Count only fresh entries from CONFIRM; saturate at all-ones.
    always_comb begin
        evt_d = evt_q;
        if ((state_q == CONFIRM) && (state_d == OVERLOAD) && (evt_q != {EVT_W{1'b1}})) begin
            evt_d = evt_q + EVT_W'(1);
        end else begin
            evt_d = evt_q;
        end
    end

    // Event counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign overload_events = evt_q;
`endif

endmodule

// File: tb/tb_overload_interlock.sv
// ---------------------------------------------------------------------------
// tb_overload_interlock
// Randomised and directed stimulus against a cycle-level reference model of
// the overload rules (run lengths of qualifying samples, time since entry).
// Expected outputs are queued by the driver and popped by an independent
// monitor after each rising edge.
// ---------------------------------------------------------------------------
module tb_overload_interlock;

    localparam int DEB  = 8;
    localparam int CLR  = 16;
    localparam int HALF = 4;
`ifdef OVERLOAD_EVENT_COUNTER_EN
    localparam int EVT_MAX = 3;
`else
    localparam int EVT_MAX = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wle = 1'b0;
    logic cm = 1'b0;
    logic ovl, door, inh, buzz;
`ifdef OVERLOAD_EVENT_COUNTER_EN
    logic [1:0] evts;
`endif

    always #5 clk = ~clk;

    overload_interlock #(
        .DEBOUNCE_CYCLES  (DEB),
        .CLEAR_CYCLES     (CLR),
        .BUZZ_HALF_PERIOD (HALF),
        .CNT_W            (5)
`ifdef OVERLOAD_EVENT_COUNTER_EN
        ,
        .EVT_W            (2)
`endif
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .weight_limit_exceeded (wle),
        .car_moving            (cm),
        .overload_active       (ovl),
        .door_hold_open        (door),
        .motion_inhibit        (inh),
        .buzzer                (buzz)
`ifdef OVERLOAD_EVENT_COUNTER_EN
        ,
        .overload_events       (evts)
`endif
    );

    typedef struct packed {
        logic       ovl;
        logic       door;
        logic       inh;
        logic       buzz;
        logic [7:0] evt;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    // Reference model state
    bit raw_h1, raw_h2;
    bit m_lat;
    int hi_run, lo_run, since_entry, m_evt;

    function automatic logic [7:0] dut_evt();
`ifdef OVERLOAD_EVENT_COUNTER_EN
        return {6'd0, evts};
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        raw_h1 = 1'b0;
        raw_h2 = 1'b0;
        m_lat = 1'b0;
        hi_run = 0;
        lo_run = 0;
        since_entry = 0;
        m_evt = 0;
    endtask

    // One rising edge: the logic sees the raw flag from two edges earlier.
    task automatic model_step(input bit r, input bit c);
        bit lim;
        lim = raw_h2;
        raw_h2 = raw_h1;
        raw_h1 = r;
        if (!m_lat) begin
            hi_run = (lim && !c) ? hi_run + 1 : 0;
            if (hi_run >= DEB) begin
                m_lat = 1'b1;
                hi_run = 0;
                lo_run = 0;
                since_entry = 0;
                if (m_evt < EVT_MAX) m_evt++;
            end
        end else begin
            since_entry++;
            lo_run = lim ? 0 : lo_run + 1;
            if (lo_run >= CLR) begin
                m_lat = 1'b0;
                lo_run = 0;
                since_entry = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ovl  = m_lat;
        e.door = m_lat;
        e.inh  = m_lat;
        e.buzz = m_lat && (((since_entry / HALF) % 2) == 0);
        e.evt  = 8'(m_evt);
        return e;
    endfunction

    // Inputs change on the falling edge; the expectation for the next rising edge is queued.
    task automatic drive(input bit r, input bit c);
        @(negedge clk);
        wle = r;
        cm = c;
        model_step(r, c);
        expq.push_back(model_out());
    endtask

    task automatic run(input int n, input bit r, input bit c);
        for (int i = 0; i < n; i++) drive(r, c);
    endtask

    // Monitor: pop and compare one expectation after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && expq.size() > 0) begin
                e = expq.pop_front();
                chk("outputs{ovl,door,inh,buzz,evt}",
                    {20'd0, ovl, door, inh, buzz, dut_evt()},
                    {20'd0, e.ovl, e.door, e.inh, e.buzz, e.evt});
            end
        end
    end

    initial begin
        model_reset();
        #12;
        chk("reset_outputs", {28'd0, ovl, door, inh, buzz}, 32'd0);
        chk("reset_events", {24'd0, dut_evt()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run(4, 1'b0, 1'b0);
        // Glitch shorter than the debounce window
        run(5, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        chk("glitch_no_overload", {31'd0, ovl}, 32'd0);
        // Entry and buzzer pattern
        run(20, 1'b1, 1'b0);
        chk("entry_overload", {29'd0, ovl, door, inh}, 32'd7);
        // Short drop, re-entry, then full release
        run(10, 1'b0, 1'b0);
        run(8, 1'b1, 1'b0);
        chk("reentry_held", {31'd0, ovl}, 32'd1);
        run(22, 1'b0, 1'b0);
        chk("released", {28'd0, ovl, door, inh, buzz}, 32'd0);
        // Moving car blocks entry, then stopping permits it
        run(20, 1'b1, 1'b1);
        chk("moving_blocks", {31'd0, ovl}, 32'd0);
        run(12, 1'b1, 1'b0);
        chk("stopped_enters", {31'd0, ovl}, 32'd1);
        run(22, 1'b0, 1'b1);
        chk("moving_ignored_release", {31'd0, ovl}, 32'd0);

        // Random segments
        for (int s = 0; s < 80; s++) begin
            int kind, len;
            kind = $urandom_range(0, 4);
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0: drive(1'b1, 1'b0);
                    1: drive(1'b0, 1'(($urandom_range(0, 7)) == 0));
                    2: drive(1'b1, 1'($urandom_range(0, 1)));
                    3: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    default: drive(1'($urandom_range(0, 5) != 0), 1'b0);
                endcase
            end
        end
        run(22, 1'b0, 1'b0);

        // Five full overload cycles (event counter saturation)
        for (int k = 0; k < 5; k++) begin
            run(14, 1'b1, 1'b0);
            run(22, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of an overload
        run(14, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        chk("pre_reset_overload", {31'd0, ovl}, 32'd1);
        mon_en = 1'b0;
        expq.delete();
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {28'd0, ovl, door, inh, buzz}, 32'd0);
        chk("async_reset_events", {24'd0, dut_evt()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        run(6, 1'b1, 1'b0);
        run(6, 1'b0, 1'b0);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #2;
        if (expq.size() > 0) chk("drain_queue", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
